// File: rtl/sevenseg_reader.sv
// Reads back a multiplexed active-low seven-segment bus: synchronises the pins,
// accepts each digit after it has been stable, and presents a full frame with a valid pulse.
module sevenseg_reader #(
  parameter int NDIGITS       = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             segments,
  input  logic [NDIGITS-1:0]     an,
  output logic [4*NDIGITS-1:0]   value,
  output logic [NDIGITS-1:0]     blank_mask,
  output logic                   error,
  output logic                   valid
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [6:0]                seg_s1_q, seg_s2_q;
  logic [NDIGITS-1:0]        an_s1_q, an_s2_q;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [NDIGITS-1:0][3:0]   nib_q, nib_d, value_q;
  logic [NDIGITS-1:0]        blk_q, blk_d, mask_q, mask_d, blank_q;
  logic                      ferr_q, ferr_d, err_q, valid_q;

  logic                      stable, accept, complete;
  logic [NDIGITS-1:0]        an_n;
  logic                      sel_none, sel_one;
  logic [3:0]                dec_nib;
  logic                      dec_blank, dec_err;

  // s1 holds the sample s2 is about to take; equality means this edge is a stable one
  assign stable   = (seg_s1_q == seg_s2_q) && (an_s1_q == an_s2_q);
  assign accept   = stable && (cnt_q == CW'(STABLE_CYCLES - 1));
  assign complete = &mask_q;

  assign an_n     = ~an_s2_q;
  assign sel_none = (an_n == '0);
  assign sel_one  = !sel_none && ((an_n & (an_n - 1'b1)) == '0);

  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg_s2_q)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h18: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h27: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0e: dec_nib = 4'hF;
      7'h7f: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  always_comb begin
    if (!stable)                           cnt_d = '0;
    else if (cnt_q != CW'(STABLE_CYCLES))  cnt_d = cnt_q + 1'b1;
    else                                   cnt_d = cnt_q;
  end

  // Completion clears the frame state first so a same-edge acceptance opens the next frame
  always_comb begin
    nib_d  = nib_q;
    blk_d  = blk_q;
    mask_d = complete ? '0 : mask_q;
    ferr_d = complete ? 1'b0 : ferr_q;
    if (accept) begin
      if (sel_one) begin
        for (int i = 0; i < NDIGITS; i++) begin
          if (an_n[i]) begin
            nib_d[i] = dec_nib;
            blk_d[i] = dec_blank;
          end
        end
        mask_d = mask_d | an_n;
        ferr_d = ferr_d | dec_err;
      end else if (!sel_none) begin
        ferr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_s1_q <= 7'h7f;
      seg_s2_q <= 7'h7f;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
      cnt_q    <= '0;
      nib_q    <= '0;
      blk_q    <= '0;
      mask_q   <= '0;
      ferr_q   <= 1'b0;
      value_q  <= '0;
      blank_q  <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      seg_s1_q <= segments;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
      cnt_q    <= cnt_d;
      nib_q    <= nib_d;
      blk_q    <= blk_d;
      mask_q   <= mask_d;
      ferr_q   <= ferr_d;
      valid_q  <= complete;
      if (complete) begin
        value_q <= nib_q;
        blank_q <= blk_q;
        err_q   <= ferr_q;
      end
    end
  end

  assign value      = value_q;
  assign blank_mask = blank_q;
  assign error      = err_q;
  assign valid      = valid_q;
endmodule

// File: tb/tb_sevenseg_reader.sv
// Scoreboard bench for sevenseg_reader: each completed scan pushes its expected frame,
// and the monitor pops and compares on every valid pulse.
module tb_sevenseg_reader;
  localparam int ND = 4;
  localparam int S  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    segments;
  logic [ND-1:0] an;
  logic [4*ND-1:0] value;
  logic [ND-1:0] blank_mask;
  logic          error, valid;

  always #5 clk = ~clk;

  sevenseg_reader #(.NDIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .segments(segments), .an(an),
    .value(value), .blank_mask(blank_mask), .error(error), .valid(valid)
  );

  typedef struct packed {
    logic [4*ND-1:0] v;
    logic [ND-1:0]   b;
    logic            e;
  } frame_t;

  frame_t sbq[$];
  int nchk = 0, nerr = 0;
  int cyc = 0, vcount = 0, npush = 0;
  int t_apply = 0, t_valid = 0;
  logic prev_v = 1'b0;

  logic [4*ND-1:0] m_val;
  logic [ND-1:0]   m_blk, m_mask;
  logic            m_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // {err, blank, nibble}
  function automatic logic [5:0] dec(input logic [6:0] s);
    case (s)
      7'h40: return 6'h00; 7'h79: return 6'h01; 7'h24: return 6'h02; 7'h30: return 6'h03;
      7'h19: return 6'h04; 7'h12: return 6'h05; 7'h02: return 6'h06; 7'h78: return 6'h07;
      7'h00: return 6'h08; 7'h18: return 6'h09; 7'h08: return 6'h0A; 7'h03: return 6'h0B;
      7'h27: return 6'h0C; 7'h21: return 6'h0D; 7'h06: return 6'h0E; 7'h0e: return 6'h0F;
      7'h7f: return 6'h10;
      default: return 6'h20;
    endcase
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      frame_t f;
      chk("vwidth", {31'd0, prev_v}, 32'd0);
      vcount++;
      t_valid = cyc;
      if (sbq.size() == 0) chk("spurious", 32'd1, 32'd0);
      else begin
        f = sbq.pop_front();
        chk("value", {16'd0, value}, {16'd0, f.v});
        chk("blank", {28'd0, blank_mask}, {28'd0, f.b});
        chk("error", {31'd0, error}, {31'd0, f.e});
      end
    end
    prev_v = valid;
  end

  task automatic drive(input logic [6:0] seg, input logic [ND-1:0] a, input int n);
    @(negedge clk);
    segments = seg;
    an = a;
    t_apply = cyc;
    repeat (n) @(posedge clk);
  endtask

  task automatic digit(input int i, input logic [6:0] seg, input int n);
    logic [5:0] d;
    logic [ND-1:0] a;
    d = dec(seg);
    m_val[4*i +: 4] = d[3:0];
    m_blk[i] = d[4];
    m_err = m_err | d[5];
    m_mask[i] = 1'b1;
    if (&m_mask) begin
      sbq.push_back({m_val, m_blk, m_err});
      npush++;
      m_mask = '0;
      m_err = 1'b0;
    end
    a = '1;
    a[i] = 1'b0;
    drive(seg, a, n);
  endtask

  task automatic bad_sel(input logic [ND-1:0] a, input int n);
    m_err = 1'b1;
    drive(7'h00, a, n);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    segments = 7'h7f;
    an = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_val = '0; m_blk = '0; m_mask = '0; m_err = 1'b0;
  endtask

  initial begin
    int vc0;
    reset = 1'b1;
    segments = 7'h7f;
    an = '1;
    do_reset();
    chk("rst_value", {16'd0, value}, 32'd0);
    chk("rst_blank", {28'd0, blank_mask}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);

    // Plain scan, then latency of the last digit to valid
    digit(0, 7'h24, 20); digit(1, 7'h30, 20); digit(2, 7'h19, 20); digit(3, 7'h12, 20);
    chk("latency", t_valid - t_apply, S + 3);

    // Invalid pattern on digit 1, blank on digit 2
    digit(0, 7'h24, 20); digit(1, 7'h7e, 20); digit(2, 7'h7f, 20); digit(3, 7'h12, 20);

    // Bounce on digit 0 must not be accepted until it settles on 79
    for (int j = 0; j < 10; j++) drive((j % 2) ? 7'h79 : 7'h40, 4'b1110, 3);
    digit(0, 7'h79, 20); digit(1, 7'h00, 20); digit(2, 7'h00, 20); digit(3, 7'h00, 20);

    // Two selects low mid-frame taints only that frame
    digit(0, 7'h24, 20); digit(1, 7'h30, 20);
    bad_sel(4'b1100, 20);
    digit(2, 7'h19, 20); digit(3, 7'h12, 20);
    digit(0, 7'h40, 20); digit(1, 7'h79, 20); digit(2, 7'h24, 20); digit(3, 7'h30, 20);

    // Reset mid-frame discards partial digits
    digit(0, 7'h24, 20); digit(1, 7'h30, 20); digit(2, 7'h19, 20);
    vc0 = vcount;
    do_reset();
    digit(3, 7'h12, 20);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rstmid_vcount", vcount, vc0);
    chk("rstmid_value", {16'd0, value}, 32'd0);
    chk("rstmid_blank", {28'd0, blank_mask}, 32'd0);
    chk("rstmid_error", {31'd0, error}, 32'd0);

    // Continuous scan, three frames
    do_reset();
    vc0 = vcount;
    for (int f = 0; f < 3; f++) begin
      digit(0, 7'h27, 20); digit(1, 7'h21, 20); digit(2, 7'h06, 20); digit(3, 7'h0e, 20);
    end
    repeat (5) @(posedge clk);
    chk("cont_vcount", vcount - vc0, 3);

    for (int k = 0; k < 50 && sbq.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk("drain", sbq.size(), 0);
    chk("total_frames", vcount, npush);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
